// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, reads instruction memory and
// queues returned words with their PCs in a 2-entry buffer for decode.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0040_0000,
  parameter int unsigned IMEM_WORDS = 1024
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  output logic        imem_rena_o,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_data_i,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_pc_i,
  output logic        inst_valid_o,
  input  logic        inst_ready_i,
  output logic [31:0] inst_out_o,
  output logic [31:0] inst_pc_o,
  output logic [31:0] inst_pc_plus4_o,
  output logic        fetch_fault_o
);

  // One past the last valid byte; 33 bits so the bound cannot wrap.
  localparam logic [32:0] WinEnd = {1'b0, RESET_PC} + (33'(IMEM_WORDS) << 2);

  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] buf_word_q [2];
  logic [31:0] buf_pc_q   [2];
  logic        wr_ptr_q, wr_ptr_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic [1:0]  count_q, count_d;

  logic bad, pop, issue;

  // Fault and handshake decode from current state.
  always_comb begin
    bad = (fetch_pc_q[1:0] != 2'b00) | (fetch_pc_q < RESET_PC) |
          ({1'b0, fetch_pc_q} >= WinEnd);
    inst_valid_o = (count_q != 2'd0);
    pop          = inst_valid_o & inst_ready_i;
    issue        = !bad & !redirect_valid_i & ((count_q < 2'd2) | pop);
  end

  // Output drive; head fields read as zero while the buffer is empty.
  always_comb begin
    imem_rena_o   = issue;
    imem_addr_o   = fetch_pc_q;
    fetch_fault_o = bad;
    if (inst_valid_o) begin
      inst_out_o      = buf_word_q[rd_ptr_q];
      inst_pc_o       = buf_pc_q[rd_ptr_q];
      inst_pc_plus4_o = buf_pc_q[rd_ptr_q] + 32'd4;
    end else begin
      inst_out_o      = 32'h0;
      inst_pc_o       = 32'h0;
      inst_pc_plus4_o = 32'h0;
    end
  end

  // Next-state: a redirect flushes the buffer and suppresses the push.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (redirect_valid_i) begin
      fetch_pc_d = redirect_pc_i;
      wr_ptr_d   = 1'b0;
      rd_ptr_d   = 1'b0;
      count_d    = 2'd0;
    end else begin
      if (issue) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
        wr_ptr_d   = ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      count_d = count_q + {1'b0, issue} - {1'b0, pop};
    end
  end

  // Control state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fetch_pc_q <= RESET_PC;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // Buffer storage; written only on an issued fetch.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 2; i++) begin
        buf_word_q[i] <= 32'h0;
        buf_pc_q[i]   <= 32'h0;
      end
    end else if (issue) begin
      buf_word_q[wr_ptr_q] <= imem_data_i;
      buf_pc_q[wr_ptr_q]   <= fetch_pc_q;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: per-cycle vector table plus a mid-cycle reset.
module tb_fetch_unit;

  localparam logic [31:0] Base = 32'h0040_0000;

  logic        clk, rst_n;
  logic        imem_rena, redirect_valid, inst_valid, inst_ready, fetch_fault;
  logic [31:0] imem_addr, imem_data, redirect_pc, inst_out, inst_pc, inst_pc_plus4;

  int n_pass = 0;
  int n_total = 0;

  fetch_unit #(.RESET_PC(Base), .IMEM_WORDS(1024)) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .imem_rena_o     (imem_rena),
    .imem_addr_o     (imem_addr),
    .imem_data_i     (imem_data),
    .redirect_valid_i(redirect_valid),
    .redirect_pc_i   (redirect_pc),
    .inst_valid_o    (inst_valid),
    .inst_ready_i    (inst_ready),
    .inst_out_o      (inst_out),
    .inst_pc_o       (inst_pc),
    .inst_pc_plus4_o (inst_pc_plus4),
    .fetch_fault_o   (fetch_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: word = A000_0000 | word index.
  always_comb imem_data = 32'hA000_0000 | ((imem_addr - Base) >> 2);

  typedef struct {
    bit          rdy;
    bit          rv;
    logic [31:0] rpc;
    bit          vld;
    logic [31:0] out;
    logic [31:0] pc;
    bit          rena;
    bit          fault;
    logic [31:0] addr;
  } vec_t;

  vec_t vecs[35];

  function automatic vec_t mk(bit rdy, bit rv, logic [31:0] rpc, bit vld, logic [31:0] out,
                              logic [31:0] pc, bit rena, bit fault, logic [31:0] addr);
    vec_t v;
    v.rdy = rdy; v.rv = rv; v.rpc = rpc; v.vld = vld; v.out = out; v.pc = pc;
    v.rena = rena; v.fault = fault; v.addr = addr;
    return v;
  endfunction

  function automatic logic [31:0] w(int i);
    return 32'hA000_0000 | 32'(i);
  endfunction

  function automatic logic [31:0] p(int i);
    return Base + 32'(4 * i);
  endfunction

  task automatic check(string name, int idx, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s vec%0d: got %h expected %h", name, idx, act, exp);
  endtask

  // Drive one cycle's inputs, compare outputs before the edge, then clock.
  task automatic step(int idx);
    vec_t v = vecs[idx];
    inst_ready     = v.rdy;
    redirect_valid = v.rv;
    redirect_pc    = v.rpc;
    #1;
    check("inst_valid", idx, 32'(inst_valid), 32'(v.vld));
    check("inst_out", idx, inst_out, v.vld ? v.out : 32'h0);
    check("inst_pc", idx, inst_pc, v.vld ? v.pc : 32'h0);
    check("inst_pc_plus4", idx, inst_pc_plus4, v.vld ? v.pc + 32'd4 : 32'h0);
    check("imem_rena", idx, 32'(imem_rena), 32'(v.rena));
    check("fetch_fault", idx, 32'(fetch_fault), 32'(v.fault));
    check("imem_addr", idx, imem_addr, v.addr);
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Streaming with ready high.
    vecs[0]  = mk(1, 0, 0, 0, 0,     0,     1, 0, p(0));
    vecs[1]  = mk(1, 0, 0, 1, w(0),  p(0),  1, 0, p(1));
    vecs[2]  = mk(1, 0, 0, 1, w(1),  p(1),  1, 0, p(2));
    vecs[3]  = mk(1, 0, 0, 1, w(2),  p(2),  1, 0, p(3));
    // Backpressure: fill to 2, hold, then resume.
    vecs[4]  = mk(0, 0, 0, 1, w(3),  p(3),  1, 0, p(4));
    vecs[5]  = mk(0, 0, 0, 1, w(3),  p(3),  0, 0, p(5));
    vecs[6]  = mk(0, 0, 0, 1, w(3),  p(3),  0, 0, p(5));
    vecs[7]  = mk(1, 0, 0, 1, w(3),  p(3),  1, 0, p(5));
    // Redirect with count=2, head 0x00400010 consumed, 0x00400014 dropped.
    vecs[8]  = mk(1, 1, 32'h0040_0100, 1, w(4), p(4), 0, 0, p(6));
    vecs[9]  = mk(1, 0, 0, 0, 0,     0,     1, 0, 32'h0040_0100);
    vecs[10] = mk(1, 0, 0, 1, w(64), p(64), 1, 0, 32'h0040_0104);
    // Misaligned redirect, then recovery.
    vecs[11] = mk(1, 1, 32'h0040_0102, 1, w(65), p(65), 0, 0, 32'h0040_0108);
    vecs[12] = mk(1, 0, 0, 0, 0,     0,     0, 1, 32'h0040_0102);
    vecs[13] = mk(1, 0, 0, 0, 0,     0,     0, 1, 32'h0040_0102);
    vecs[14] = mk(1, 1, 32'h0040_0010, 0, 0, 0, 0, 1, 32'h0040_0102);
    vecs[15] = mk(1, 0, 0, 0, 0,     0,     1, 0, p(4));
    vecs[16] = mk(1, 0, 0, 1, w(4),  p(4),  1, 0, p(5));
    // End of window.
    vecs[17] = mk(1, 1, 32'h0040_0FF8, 1, w(5), p(5), 0, 0, p(6));
    vecs[18] = mk(1, 0, 0, 0, 0,      0,      1, 0, p(1022));
    vecs[19] = mk(1, 0, 0, 1, w(1022), p(1022), 1, 0, p(1023));
    vecs[20] = mk(1, 0, 0, 1, w(1023), p(1023), 0, 1, 32'h0040_1000);
    vecs[21] = mk(1, 0, 0, 0, 0,      0,      0, 1, 32'h0040_1000);
    // Below-window redirect, then back to base.
    vecs[22] = mk(1, 1, 32'h003F_FFFC, 0, 0, 0, 0, 1, 32'h0040_1000);
    vecs[23] = mk(1, 0, 0, 0, 0,     0,     0, 1, 32'h003F_FFFC);
    vecs[24] = mk(1, 1, Base, 0, 0,  0,     0, 1, 32'h003F_FFFC);
    vecs[25] = mk(1, 0, 0, 0, 0,     0,     1, 0, p(0));
    vecs[26] = mk(1, 0, 0, 1, w(0),  p(0),  1, 0, p(1));
    // After mid-cycle reset: ready low for 5 cycles, then release.
    vecs[27] = mk(0, 0, 0, 0, 0,     0,     1, 0, p(0));
    vecs[28] = mk(0, 0, 0, 1, w(0),  p(0),  1, 0, p(1));
    vecs[29] = mk(0, 0, 0, 1, w(0),  p(0),  0, 0, p(2));
    vecs[30] = mk(0, 0, 0, 1, w(0),  p(0),  0, 0, p(2));
    vecs[31] = mk(0, 0, 0, 1, w(0),  p(0),  0, 0, p(2));
    vecs[32] = mk(1, 0, 0, 1, w(0),  p(0),  1, 0, p(2));
    vecs[33] = mk(1, 0, 0, 1, w(1),  p(1),  1, 0, p(3));
    vecs[34] = mk(1, 0, 0, 1, w(2),  p(2),  1, 0, p(4));

    rst_n = 1'b0;
    inst_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;

    for (int i = 0; i < 27; i++) step(i);

    // Asynchronous reset between edges clears state without a clock.
    #2 rst_n = 1'b0;
    #1;
    check("rst_inst_valid", 99, 32'(inst_valid), 32'h0);
    check("rst_inst_out", 99, inst_out, 32'h0);
    check("rst_imem_addr", 99, imem_addr, Base);
    check("rst_fetch_fault", 99, 32'(fetch_fault), 32'h0);
    @(posedge clk);
    #2 rst_n = 1'b1;

    for (int i = 27; i < 35; i++) step(i);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
